regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_sb.sv | 178 +++++++++++++++++
 tb/tb_regfile_sb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bus bundle for the scoreboarded register file.
//   master : read addresses, write port, reserve port, clear request (driver side)
//   slave  : the register file; returns read data/busy and clr_busy
// AW is derived from NREGS so both ends agree on address width.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;
  logic [AW-1:0]   rd_addr;
  logic            reg_write;
  logic [XLEN-1:0] wr_data;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            clr_req;
  logic            clr_busy;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, reg_write, wr_data,
           rsv_valid, rsv_addr, clr_req,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, clr_busy
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, reg_write, wr_data,
           rsv_valid, rsv_addr, clr_req,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-register pending-write scoreboard
// and a sequential whole-file clear.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (zeroes file, scoreboard, FSM)
//   bus  : regfile_sb_if.slave
//          rs1/rs2 : combinational read data + busy flag
//          rd_addr/reg_write/wr_data : write port (clears busy)
//          rsv_valid/rsv_addr        : reserve port (sets busy, wins on tie)
//          clr_req/clr_busy          : start / status of the clear walk
// Register 0 is hardwired to zero and never busy; addresses >= NREGS are
// ignored on writes/reserves and read as zero.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle accepted write data
// to matching read ports (busy reflects a same-cycle reserve only).

// One combinational read port.
module regfile_sb_rdport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy_vec,
  output logic [XLEN-1:0]             data,
  output logic                        busy
);
  logic hit;

  always_comb begin
    hit  = (addr != '0) && (32'(addr) < NREGS);
    data = hit ? regs[addr] : '0;
    busy = hit ? busy_vec[addr] : 1'b0;
  end
endmodule

module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW    = $clog2(NREGS);
  localparam int NRD   = 2;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              idx_q, idx_d;
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  logic                       clr_busy;
  logic                       wr_ok, rsv_ok;

  logic [NRD-1:0][AW-1:0]     ra;
  logic [NRD-1:0][XLEN-1:0]   rd_raw, rd_out;
  logic [NRD-1:0]             rb_raw, rb_out;

  // Write/reserve are locked out for the whole clear walk.
  always_comb begin
    wr_ok  = bus.reg_write && (bus.rd_addr != '0) &&
             (32'(bus.rd_addr) < NREGS) && !clr_busy;
    rsv_ok = bus.rsv_valid && (bus.rsv_addr != '0) &&
             (32'(bus.rsv_addr) < NREGS) && !clr_busy;
  end

  // ---------------- clear FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------- clear FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          idx_d   = AW'(1);
        end
      end
      S_CLEAR: begin
        // clr_req is deliberately not looked at here: no restart mid-walk.
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------- clear FSM: outputs ----------------
  always_comb begin
    clr_busy = (state_q == S_CLEAR);
  end

  assign bus.clr_busy = clr_busy;

  // ---------------- file + scoreboard ----------------
  // Order matters: write clears busy, reserve then re-sets it (reserve wins),
  // clear walk last. Entry 0 is pinned to zero.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[bus.rd_addr] = bus.wr_data;
      busy_d[bus.rd_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
    if (state_q == S_CLEAR) begin
      regs_d[idx_q] = '0;
      busy_d[idx_q] = 1'b0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // ---------------- read ports ----------------
  assign ra[0] = bus.rs1_addr;
  assign ra[1] = bus.rs2_addr;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_rd (
      .addr    (ra[p]),
      .regs    (regs_q),
      .busy_vec(busy_q),
      .data    (rd_raw[p]),
      .busy    (rb_raw[p])
    );

`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes address 0 / out-of-range, so a hit is always legal.
    logic hit;
    assign hit       = wr_ok && (ra[p] == bus.rd_addr);
    assign rd_out[p] = hit ? bus.wr_data : rd_raw[p];
    assign rb_out[p] = hit ? (rsv_ok && (bus.rsv_addr == ra[p])) : rb_raw[p];
`else
    assign rd_out[p] = rd_raw[p];
    assign rb_out[p] = rb_raw[p];
`endif
  end

  assign bus.rs1_data = rd_out[0];
  assign bus.rs2_data = rd_out[1];
  assign bus.rs1_busy = rb_out[0];
  assign bus.rs2_busy = rb_out[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a 32-entry instance for the main function
// and clear walk, and a 12-entry instance for out-of-range addressing.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREGS(32)) bi ();
  regfile_sb_if #(.XLEN(32), .NREGS(12)) bj ();

  regfile_sb #(.XLEN(32), .NREGS(32)) u_dut (
    .clk(clk), .rst(rst), .bus(bi.slave)
  );
  regfile_sb #(.XLEN(32), .NREGS(12)) u_dut12 (
    .clk(clk), .rst(rst), .bus(bj.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fillv(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    int k;
    // all inputs quiet
    bi.rs1_addr = '0; bi.rs2_addr = '0; bi.rd_addr = '0; bi.reg_write = 1'b0;
    bi.wr_data = '0; bi.rsv_valid = 1'b0; bi.rsv_addr = '0; bi.clr_req = 1'b0;
    bj.rs1_addr = '0; bj.rs2_addr = '0; bj.rd_addr = '0; bj.reg_write = 1'b0;
    bj.wr_data = '0; bj.rsv_valid = 1'b0; bj.rsv_addr = '0; bj.clr_req = 1'b0;
    rst = 1'b1;
    #2;
    bi.rs1_addr = 5'd5; bi.rs2_addr = 5'd7;
    #1;
    chk("rst_clr_busy", bi.clr_busy, 0);
    chk("rst_rs1_data", bi.rs1_data, 0);
    chk("rst_rs1_busy", bi.rs1_busy, 0);
    chk("rst_rs2_busy", bi.rs2_busy, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // write x5, visible next cycle; pre-edge read shows old contents
    bi.rd_addr = 5'd5; bi.wr_data = 32'hDEADBEEF; bi.reg_write = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x5_pre_edge", bi.rs1_data, 32'hDEADBEEF);
`else
    chk("x5_pre_edge", bi.rs1_data, 32'h0);
`endif
    cyc();
    bi.reg_write = 1'b0;
    #1;
    chk("x5_data", bi.rs1_data, 32'hDEADBEEF);
    chk("x5_busy", bi.rs1_busy, 0);

    // write to x0 is dropped
    bi.rd_addr = 5'd0; bi.wr_data = 32'h12345678; bi.reg_write = 1'b1;
    cyc();
    bi.reg_write = 1'b0; bi.rs1_addr = 5'd0;
    #1;
    chk("x0_data", bi.rs1_data, 0);
    chk("x0_busy", bi.rs1_busy, 0);

    // reserve / write / same-edge write+reserve on x7
    bi.rsv_valid = 1'b1; bi.rsv_addr = 5'd7;
    cyc();
    bi.rsv_valid = 1'b0;
    #1;
    chk("x7_rsv_busy", bi.rs2_busy, 1);
    bi.rd_addr = 5'd7; bi.wr_data = 32'hA5; bi.reg_write = 1'b1;
    cyc();
    bi.reg_write = 1'b0;
    #1;
    chk("x7_wr_busy", bi.rs2_busy, 0);
    chk("x7_wr_data", bi.rs2_data, 32'hA5);
    bi.rd_addr = 5'd7; bi.wr_data = 32'hA5; bi.reg_write = 1'b1;
    bi.rsv_valid = 1'b1; bi.rsv_addr = 5'd7;
    cyc();
    bi.reg_write = 1'b0; bi.rsv_valid = 1'b0;
    #1;
    chk("x7_tie_busy", bi.rs2_busy, 1);
    chk("x7_tie_data", bi.rs2_data, 32'hA5);

    // write x8 and reserve x9 on one edge
    bi.rd_addr = 5'd8; bi.wr_data = 32'h11; bi.reg_write = 1'b1;
    bi.rsv_valid = 1'b1; bi.rsv_addr = 5'd9;
    cyc();
    bi.reg_write = 1'b0; bi.rsv_valid = 1'b0;
    bi.rs1_addr = 5'd8; bi.rs2_addr = 5'd9;
    #1;
    chk("x8_data", bi.rs1_data, 32'h11);
    chk("x8_busy", bi.rs1_busy, 0);
    chk("x9_busy", bi.rs2_busy, 1);

    // x3: old value then 0x55
    bi.rd_addr = 5'd3; bi.wr_data = 32'h33; bi.reg_write = 1'b1;
    cyc();
    bi.rs1_addr = 5'd3; bi.wr_data = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x3_same_cycle", bi.rs1_data, 32'h55);
    chk("x3_same_busy", bi.rs1_busy, 0);
`else
    chk("x3_same_cycle", bi.rs1_data, 32'h33);
`endif
    cyc();
    bi.reg_write = 1'b0;
    #1;
    chk("x3_next_cycle", bi.rs1_data, 32'h55);

    // fill x1..x31, keep some busy bits set
    for (int i = 1; i < 32; i++) begin
      bi.rd_addr = 5'(i); bi.wr_data = fillv(i); bi.reg_write = 1'b1;
      cyc();
    end
    bi.reg_write = 1'b0;
    bi.rsv_valid = 1'b1; bi.rsv_addr = 5'd12;
    cyc();
    bi.rsv_valid = 1'b0;
    bi.rs1_addr = 5'd31; bi.rs2_addr = 5'd12;
    #1;
    chk("fill_x31", bi.rs1_data, fillv(31));
    chk("fill_x12_busy", bi.rs2_busy, 1);

    // clear walk with hostile traffic held throughout
    bi.clr_req = 1'b1;
    cyc();
    bi.rd_addr = 5'd20; bi.wr_data = 32'hFFFF_FFFF; bi.reg_write = 1'b1;
    bi.rsv_valid = 1'b1; bi.rsv_addr = 5'd30;
    bi.rs1_addr = 5'd3; bi.rs2_addr = 5'd31;
    k = 0;
    while (bi.clr_busy && k < 100) begin
      k++;
      if (k == 5) begin
        chk("mid_clr_x3", bi.rs1_data, 0);
        chk("mid_clr_x31", bi.rs2_data, fillv(31));
      end
      cyc();
    end
    bi.clr_req = 1'b0; bi.reg_write = 1'b0; bi.rsv_valid = 1'b0;
    chk("clr_cycles", 32'(k), 32'd31);
    for (int i = 0; i < 32; i++) begin
      bi.rs1_addr = 5'(i); bi.rs2_addr = 5'(i);
      #1;
      chk($sformatf("post_clr_data_x%0d", i), bi.rs1_data, 0);
      chk($sformatf("post_clr_busy_x%0d", i), bi.rs2_busy, 0);
    end
    cyc();
    chk("post_clr_idle", bi.clr_busy, 0);

    // reset during clear cycle 10
    bi.rd_addr = 5'd20; bi.wr_data = 32'h2020; bi.reg_write = 1'b1;
    bi.rsv_valid = 1'b1; bi.rsv_addr = 5'd21;
    cyc();
    bi.reg_write = 1'b0; bi.rsv_valid = 1'b0;
    bi.clr_req = 1'b1;
    cyc();
    bi.clr_req = 1'b0;
    repeat (9) cyc();
    bi.rs1_addr = 5'd20; bi.rs2_addr = 5'd21;
    #1;
    chk("clr10_busy", bi.clr_busy, 1);
    chk("clr10_x20_old", bi.rs1_data, 32'h2020);
    chk("clr10_x21_busy", bi.rs2_busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_clr_busy", bi.clr_busy, 0);
    chk("abort_x20", bi.rs1_data, 0);
    chk("abort_x21_busy", bi.rs2_busy, 0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("abort_idle", bi.clr_busy, 0);

    // 12-entry instance: out-of-range write/reserve/read, top entry, clear length
    bj.rd_addr = 4'd13; bj.wr_data = 32'hBAD; bj.reg_write = 1'b1;
    bj.rsv_valid = 1'b1; bj.rsv_addr = 4'd13;
    cyc();
    bj.reg_write = 1'b0; bj.rsv_valid = 1'b0;
    bj.rs1_addr = 4'd13; bj.rs2_addr = 4'd12;
    #1;
    chk("n12_x13_data", bj.rs1_data, 0);
    chk("n12_x13_busy", bj.rs1_busy, 0);
    chk("n12_x12_data", bj.rs2_data, 0);
    bj.rd_addr = 4'd11; bj.wr_data = 32'hAB; bj.reg_write = 1'b1;
    cyc();
    bj.reg_write = 1'b0; bj.rs2_addr = 4'd11;
    #1;
    chk("n12_x11_data", bj.rs2_data, 32'hAB);
    bj.clr_req = 1'b1;
    cyc();
    bj.clr_req = 1'b0;
    k = 0;
    while (bj.clr_busy && k < 100) begin
      k++;
      cyc();
    end
    chk("n12_clr_cycles", 32'(k), 32'd11);
    chk("n12_x11_cleared", bj.rs2_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
